// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcodes, FSM states, instruction classes,
// ALU operation selects and fault codes.
package legv8_pkg;

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [7:0]  OPC_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OPC_B_PFX   = 6'b000101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WB,
    ST_FAULT
  } state_t;

  typedef enum logic [2:0] {
    CL_LOAD,
    CL_STORE,
    CL_RTYPE,
    CL_CBZ,
    CL_B,
    CL_ILLEGAL
  } opclass_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASS  = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_IMEM_TO = 2'b10;
  localparam logic [1:0] FC_DMEM_TO = 2'b11;

  function automatic logic is_mem_class(input opclass_t c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

endpackage

// File: rtl/legv8_opclass_decode.sv
// Combinational opcode (instruction[31:21]) to instruction-class decoder.
module legv8_opclass_decode
  import legv8_pkg::*;
(
  input  logic [10:0] i_opcode,
  output opclass_t    o_class
);

  always_comb begin
    o_class = CL_ILLEGAL;
    if (i_opcode == OPC_LDUR) begin
      o_class = CL_LOAD;
    end else if (i_opcode == OPC_STUR) begin
      o_class = CL_STORE;
    end else if ((i_opcode == OPC_ADD) || (i_opcode == OPC_SUB) ||
                 (i_opcode == OPC_AND) || (i_opcode == OPC_ORR)) begin
      o_class = CL_RTYPE;
    end else if (i_opcode[10:3] == OPC_CBZ_PFX) begin
      o_class = CL_CBZ;
    end else if (i_opcode[10:5] == OPC_B_PFX) begin
      o_class = CL_B;
    end
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory
// handshakes, timeout detection, sticky fault state and a retire counter.
module legv8_multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear_fault,
  input  logic [10:0]      opcode,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             reg2loc,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             retired,
  output logic [CNT_W-1:0] instr_count,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  opclass_t         r_class;
  opclass_t         w_class;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_fcode;
  logic             w_ls;

  legv8_opclass_decode u_opclass_decode (
    .i_opcode (opcode),
    .o_class  (w_class)
  );

  assign w_ls        = is_mem_class(r_class);
  assign instr_count = r_count;
  assign fault_code  = r_fcode;

  // Strobes are decoded from the registered state; only the handshake and
  // CBZ condition inputs feed through combinationally.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    fault      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      ST_DECODE: reg2loc = w_ls;
      ST_EXECUTE: begin
        reg2loc = w_ls;
        alu_src = w_ls;
        if (w_ls)                     alu_op = ALU_ADD;
        else if (r_class == CL_RTYPE) alu_op = ALU_FUNCT;
        else                          alu_op = ALU_PASS;
        if (r_class == CL_B) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end else if (r_class == CL_CBZ) begin
          pc_write = 1'b1;
          pc_src   = alu_zero;
        end
      end
      ST_MEM: begin
        reg2loc    = w_ls;
        alu_src    = w_ls;
        alu_op     = ALU_ADD;
        dmem_read  = (r_class == CL_LOAD);
        dmem_write = (r_class == CL_STORE);
        pc_write   = (r_class == CL_STORE) && dmem_ready;
      end
      ST_WB: begin
        reg2loc    = w_ls;
        alu_op     = (r_class == CL_RTYPE) ? ALU_FUNCT : ALU_ADD;
        reg_write  = 1'b1;
        mem_to_reg = (r_class == CL_LOAD);
        pc_write   = 1'b1;
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
    retired = pc_write;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_class <= CL_ILLEGAL;
      r_wait  <= '0;
      r_count <= '0;
      r_fcode <= FC_NONE;
    end else begin
      if (ir_write) r_class <= w_class;
      if (retired)  r_count <= r_count + 1'b1;
      // Counter clears by default; only a state that keeps waiting advances it.
      r_wait <= '0;
      case (r_state)
        ST_IDLE: if (run) r_state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ready) begin
            r_state <= ST_DECODE;
          end else if (r_wait == WAIT_LAST) begin
            r_state <= ST_FAULT;
            r_fcode <= FC_IMEM_TO;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_DECODE: begin
          if (r_class == CL_ILLEGAL) begin
            r_state <= ST_FAULT;
            r_fcode <= FC_ILLEGAL;
          end else begin
            r_state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if ((r_class == CL_B) || (r_class == CL_CBZ)) r_state <= run ? ST_FETCH : ST_IDLE;
          else if (r_class == CL_RTYPE)                 r_state <= ST_WB;
          else                                          r_state <= ST_MEM;
        end
        ST_MEM: begin
          if (dmem_ready) begin
            if (r_class == CL_STORE) r_state <= run ? ST_FETCH : ST_IDLE;
            else                     r_state <= ST_WB;
          end else if (r_wait == WAIT_LAST) begin
            r_state <= ST_FAULT;
            r_fcode <= FC_DMEM_TO;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_WB: r_state <= run ? ST_FETCH : ST_IDLE;
        ST_FAULT: begin
          if (clear_fault) begin
            r_state <= ST_IDLE;
            r_fcode <= FC_NONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench: a per-cycle schedule of inputs and expected outputs is built
// from instruction-level rules, then replayed against the controller.
module tb_legv8_multicycle_ctrl;

  localparam int unsigned T     = 16;
  localparam int unsigned CW    = 4;
  localparam int unsigned CMASK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, run, clear_fault, alu_zero, imem_ready, dmem_ready;
  logic [10:0]   opcode;
  logic          imem_req, ir_write, reg2loc, alu_src, mem_to_reg, reg_write;
  logic          dmem_read, dmem_write, pc_write, pc_src, retired, fault;
  logic [1:0]    alu_op, fault_code;
  logic [CW-1:0] instr_count;

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear_fault(clear_fault),
    .opcode(opcode), .alu_zero(alu_zero), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_write(ir_write),
    .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .pc_write(pc_write), .pc_src(pc_src),
    .retired(retired), .instr_count(instr_count), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, ir_write, reg2loc, alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg, reg_write, dmem_read, dmem_write;
    logic       pc_write, pc_src, retired, fault;
    logic [1:0] fault_code;
  } out_t;

  typedef struct {
    bit          rst, run, clr, az, ir, dr, mclr;
    logic [10:0] opc;
    out_t        o;
    int unsigned cnt;
    int          pid, pval;
  } ent_t;

  ent_t        sched[$];
  ent_t        cur;
  bit          cur_valid = 1'b0;
  int          cur_idx   = 0;
  int unsigned m_count   = 0;
  logic [1:0]  m_code    = 2'b00;
  bit          m_clr     = 1'b0;
  bit          m_mclr    = 1'b0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  // Instruction classes: 0 load, 1 store, 2 R-type, 3 CBZ, 4 B, 5 illegal.
  function automatic int classify(input logic [10:0] opc);
    if (opc == 11'b11111000010) return 0;
    if (opc == 11'b11111000000) return 1;
    if (opc == 11'b10001011000 || opc == 11'b11001011000 ||
        opc == 11'b10001010000 || opc == 11'b10101010000) return 2;
    if (opc[10:3] == 8'b10110100) return 3;
    if (opc[10:5] == 6'b000101) return 4;
    return 5;
  endfunction

  function automatic ent_t blank();
    ent_t e;
    e.rst = 0; e.run = 0; e.clr = m_clr; e.az = 1; e.ir = 0; e.dr = 0;
    e.mclr = 0; e.opc = 11'h7FF; e.o = '0; e.cnt = m_count & CMASK;
    e.pid = 0; e.pval = 0;
    return e;
  endfunction

  task automatic push(input ent_t e);
    e.mclr = m_mclr;
    m_mclr = 0;
    sched.push_back(e);
  endtask

  task automatic idle(input int n, input bit run_last);
    for (int i = 0; i < n; i++) begin
      ent_t e = blank();
      e.run = (i == n - 1) ? run_last : 1'b0;
      push(e);
    end
  endtask

  task automatic pin(input int id, input int val);
    ent_t e = blank();
    e.pid = id; e.pval = val;
    push(e);
  endtask

  task automatic reset_cycles(input int n);
    m_count = 0; m_code = 0;
    for (int i = 0; i < n; i++) begin
      ent_t e = blank();
      e.rst = 1; e.run = 1; e.ir = 1;
      push(e);
    end
  endtask

  task automatic fetch_wait(input int n);
    for (int i = 0; i < n; i++) begin
      ent_t e = blank();
      e.run = 1; e.o.imem_req = 1;
      push(e);
    end
  endtask

  task automatic fetch_timeout();
    fetch_wait(T);
    m_code = 2'b10;
  endtask

  task automatic fault_hold(input int n);
    for (int i = 0; i <= n; i++) begin
      ent_t e = blank();
      e.run = 1; e.clr = (i == n);
      e.o.fault = 1; e.o.fault_code = m_code;
      push(e);
    end
    m_code = 2'b00;
  endtask

  task automatic instr(input logic [10:0] opc, input int iw, input int dw,
                       input bit z, input bit run_end);
    int c;
    bit ls;
    ent_t e;
    c  = classify(opc);
    ls = (c == 0) || (c == 1);
    fetch_wait(iw);
    e = blank(); e.run = 1; e.ir = 1; e.opc = opc;
    e.o.imem_req = 1; e.o.ir_write = 1;
    push(e);
    e = blank(); e.run = 1; e.o.reg2loc = ls;
    push(e);
    if (c == 5) begin
      m_code = 2'b01;
      return;
    end
    e = blank(); e.run = run_end; e.az = z;
    e.o.reg2loc = ls; e.o.alu_src = ls;
    e.o.alu_op = ls ? 2'b00 : ((c == 2) ? 2'b10 : 2'b01);
    if (c >= 3) begin
      e.o.pc_write = 1; e.o.retired = 1;
      e.o.pc_src = (c == 4) ? 1'b1 : z;
      push(e);
      m_count++;
      return;
    end
    push(e);
    if (ls) begin
      for (int i = 0; i <= dw && i < int'(T); i++) begin
        e = blank(); e.run = run_end;
        e.o.reg2loc = 1; e.o.alu_src = 1;
        e.o.dmem_read = (c == 0); e.o.dmem_write = (c == 1);
        if (i == dw) begin
          e.dr = 1;
          if (c == 1) begin e.o.pc_write = 1; e.o.retired = 1; end
        end
        push(e);
      end
      if (dw >= int'(T)) begin
        m_code = 2'b11;
        return;
      end
      if (c == 1) begin
        m_count++;
        return;
      end
    end
    e = blank(); e.run = run_end;
    e.o.reg2loc = ls; e.o.alu_op = (c == 2) ? 2'b10 : 2'b00;
    e.o.reg_write = 1; e.o.mem_to_reg = (c == 0);
    e.o.pc_write = 1; e.o.retired = 1;
    push(e);
    m_count++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at step %0d: got %0h expected %0h", nm, cur_idx, act, exp);
    end
  endtask

  function automatic string pin_name(input int id);
    case (id)
      1: return "instr_count";
      2: return "busy_cycles";
      3: return "dmem_read_cycles";
      4: return "reg_write_cycles";
      5: return "pc_write_cycles";
      6: return "retired_pulses";
      7: return "imem_req_cycles";
      8: return "last_fault_code";
      default: return "pc_src_cycles";
    endcase
  endfunction

  // Compare process: full output vector and counter every scheduled cycle,
  // plus event tallies that literal pins check at phase boundaries.
  initial begin
    int busy = 0, drc = 0, rwc = 0, pcw = 0, ret = 0, imc = 0, pcs = 0, fcl = 0;
    int val;
    out_t act;
    forever begin
      @(negedge clk);
      if (cur_valid) begin
        if (cur.mclr) begin
          busy = 0; drc = 0; rwc = 0; pcw = 0; ret = 0; imc = 0; pcs = 0; fcl = 0;
        end
        act = {imem_req, ir_write, reg2loc, alu_src, alu_op, mem_to_reg,
               reg_write, dmem_read, dmem_write, pc_write, pc_src, retired,
               fault, fault_code};
        chk("outputs", 64'(act), 64'(cur.o));
        chk("count", 64'(instr_count), 64'(cur.cnt));
        busy += int'(imem_req | reg2loc);
        drc += int'(dmem_read);  rwc += int'(reg_write);
        pcw += int'(pc_write);   ret += int'(retired);
        imc += int'(imem_req);   pcs += int'(pc_src);
        if (fault) fcl = int'(fault_code);
        if (cur.pid != 0) begin
          case (cur.pid)
            1: val = int'(instr_count);
            2: val = busy;
            3: val = drc;
            4: val = rwc;
            5: val = pcw;
            6: val = ret;
            7: val = imc;
            8: val = fcl;
            default: val = pcs;
          endcase
          chk(pin_name(cur.pid), 64'(val), 64'(cur.pval));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at step %0d", cur_idx);
    $fatal(1);
  end

  initial begin
    rst_n = 0; run = 0; clear_fault = 0; alu_zero = 0;
    imem_ready = 0; dmem_ready = 0; opcode = '0;

    reset_cycles(2);
    // ADD, zero wait
    m_mclr = 1; idle(2, 1); instr(11'b10001011000, 0, 0, 0, 0);
    pin(1, 1); pin(4, 1); pin(5, 1);
    // LDUR, data ready after 3 extra cycles
    m_mclr = 1; idle(1, 1); instr(11'b11111000010, 0, 3, 0, 0);
    pin(3, 4); pin(2, 8); pin(4, 1);
    // CBZ taken then not taken
    m_mclr = 1; idle(1, 1);
    instr(11'b10110100011, 0, 0, 1, 1); instr(11'b10110100110, 0, 0, 0, 0);
    pin(5, 2); pin(9, 1); pin(4, 0);
    // Illegal opcode, fault then clear
    m_mclr = 1; idle(1, 1); instr(11'b11111111111, 0, 0, 0, 0);
    fault_hold(3); idle(1, 0);
    pin(8, 1); pin(1, 4); pin(5, 0);
    // Back-to-back mix with clear_fault held (ignored); counter wraps to 0
    m_clr = 1; idle(1, 1);
    instr(11'b00010111111, 2, 0, 0, 1);
    instr(11'b11001011000, 1, 0, 1, 1);
    instr(11'b10001010000, 0, 0, 0, 1);
    instr(11'b10101010000, 0, 0, 0, 1);
    instr(11'b11111000010, 10, 15, 0, 1);
    instr(11'b11111000000, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) instr(11'b00010100000, 0, 0, 1, 1);
    instr(11'b10110100000, 0, 0, 0, 0);
    m_clr = 0; idle(1, 0); pin(1, 0);
    // run dropped during STUR memory phase
    m_mclr = 1; idle(1, 1); instr(11'b11111000000, 0, 2, 0, 0); idle(1, 0);
    pin(6, 1); pin(5, 1);
    // Instruction-fetch timeout
    m_mclr = 1; idle(1, 1); fetch_timeout(); fault_hold(2); idle(1, 0);
    pin(7, 16); pin(8, 2);
    // Data-memory timeout
    m_mclr = 1; idle(1, 1); instr(11'b11111000010, 0, 16, 0, 1);
    fault_hold(1); idle(1, 0); pin(8, 3); pin(1, 1);
    // Reset mid-FETCH, then recovery
    idle(1, 1); fetch_wait(3); reset_cycles(2);
    idle(1, 1); instr(11'b10001011000, 0, 0, 0, 0); pin(1, 1);

    foreach (sched[i]) begin
      @(posedge clk);
      #1;
      if (!sched[i].rst) rst_n = 1;
      run = sched[i].run; clear_fault = sched[i].clr; alu_zero = sched[i].az;
      imem_ready = sched[i].ir; dmem_ready = sched[i].dr; opcode = sched[i].opc;
      cur = sched[i]; cur_idx = i; cur_valid = 1;
      if (sched[i].rst) begin
        #1 rst_n = 0;
      end
    end
    @(posedge clk);
    #1 cur_valid = 0;
    #20;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
